// File: rtl/shared_resource_arbiter_pkg.sv
// Shared types and sizing helpers for the shared-resource arbiter slice.
package shared_resource_arbiter_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned RESP_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_1    = 2'd1,
    GNT_2    = 2'd2
  } grant_t;

  // Bits needed to hold the values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to index depth entries; never less than one.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/shared_resource_arbiter_if.sv
// Requester, resource and response signals of the shared-resource arbiter.
interface shared_resource_arbiter_if
  import shared_resource_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req_valid_1;
  logic              req_valid_2;
  logic              req_ready_1;
  logic              req_ready_2;
  logic [DATA_W-1:0] req_data_1;
  logic [DATA_W-1:0] req_data_2;

  logic              res_in_valid_1;
  logic              res_in_valid_2;
  logic [DATA_W-1:0] res_in_data;
  logic              res_out_valid_1;
  logic              res_out_valid_2;
  logic [DATA_W-1:0] res_out_data;

  logic              resp_valid_1;
  logic              resp_valid_2;
  logic              resp_ready_1;
  logic              resp_ready_2;
  logic [DATA_W-1:0] resp_data_1;
  logic [DATA_W-1:0] resp_data_2;

  // Arbiter side.
  modport slave (
    input  req_valid_1, req_valid_2, req_data_1, req_data_2,
    output req_ready_1, req_ready_2,
    output res_in_valid_1, res_in_valid_2, res_in_data,
    input  res_out_valid_1, res_out_valid_2, res_out_data,
    output resp_valid_1, resp_valid_2, resp_data_1, resp_data_2,
    input  resp_ready_1, resp_ready_2
  );

  // Requesters plus resource side.
  modport master (
    output req_valid_1, req_valid_2, req_data_1, req_data_2,
    input  req_ready_1, req_ready_2,
    input  res_in_valid_1, res_in_valid_2, res_in_data,
    output res_out_valid_1, res_out_valid_2, res_out_data,
    input  resp_valid_1, resp_valid_2, resp_data_1, resp_data_2,
    output resp_ready_1, resp_ready_2
  );

endinterface

// File: rtl/shared_resource_arbiter_resp_fifo.sv
// Per-requester response FIFO; any depth, pointers wrap modulo DEPTH.
module shared_resource_arbiter_resp_fifo
  import shared_resource_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = RESP_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pop of an empty FIFO is dropped; a full FIFO accepts a push only alongside a pop.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Two-requester front end for the 1-cycle doubling resource with credit-guarded response FIFOs.
// RR_ARB_EN selects round-robin arbitration; otherwise requester 1 has fixed priority.
module shared_resource_arbiter
  import shared_resource_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  shared_resource_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(RESP_DEPTH);

  grant_t            w_grant;
  logic              w_elig_1;
  logic              w_elig_2;
  logic              w_acc_1;
  logic              w_acc_2;
  logic              w_push_1;
  logic              w_push_2;
  logic              w_pop_1;
  logic              w_pop_2;
  logic              w_full_1;
  logic              w_full_2;
  logic              w_empty_1;
  logic              w_empty_2;
  logic [DATA_W-1:0] w_head_1;
  logic [DATA_W-1:0] w_head_2;
  logic [CNT_W-1:0]  r_credit_1;
  logic [CNT_W-1:0]  r_credit_2;
  logic              r_in_valid_1;
  logic              r_in_valid_2;
  logic [DATA_W-1:0] r_in_data;

  function automatic logic [CNT_W-1:0] credit_nxt(input logic [CNT_W-1:0] cur,
                                                  input logic acc, input logic pop);
    case ({acc, pop})
      2'b10:   return cur - CNT_W'(1);
      2'b01:   return cur + CNT_W'(1);
      default: return cur;
    endcase
  endfunction

  // A requester may only win while it still owns response buffer space.
  assign w_elig_1 = bus.req_valid_1 && (r_credit_1 != '0);
  assign w_elig_2 = bus.req_valid_2 && (r_credit_2 != '0);

`ifdef RR_ARB_EN
  logic r_prio_2;
  logic w_prio_2_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prio_2 <= 1'b0;
    else          r_prio_2 <= w_prio_2_nxt;
  end

  // Any accept hands priority to the other requester.
  always_comb begin
    w_prio_2_nxt = r_prio_2;
    if (w_grant == GNT_1)      w_prio_2_nxt = 1'b1;
    else if (w_grant == GNT_2) w_prio_2_nxt = 1'b0;
  end

  always_comb begin
    w_grant = GNT_NONE;
    if (w_elig_1 && w_elig_2) w_grant = r_prio_2 ? GNT_2 : GNT_1;
    else if (w_elig_1)        w_grant = GNT_1;
    else if (w_elig_2)        w_grant = GNT_2;
  end
`else
  always_comb begin
    w_grant = GNT_NONE;
    if (w_elig_1)      w_grant = GNT_1;
    else if (w_elig_2) w_grant = GNT_2;
  end
`endif

  assign w_acc_1 = (w_grant == GNT_1);
  assign w_acc_2 = (w_grant == GNT_2);
  assign bus.req_ready_1 = w_acc_1;
  assign bus.req_ready_2 = w_acc_2;

  // Issue register: one-hot valid toward the resource, data held when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_valid_1 <= 1'b0;
      r_in_valid_2 <= 1'b0;
      r_in_data    <= '0;
    end else begin
      case (w_grant)
        GNT_1: begin
          r_in_valid_1 <= 1'b1;
          r_in_valid_2 <= 1'b0;
          r_in_data    <= bus.req_data_1;
        end
        GNT_2: begin
          r_in_valid_1 <= 1'b0;
          r_in_valid_2 <= 1'b1;
          r_in_data    <= bus.req_data_2;
        end
        default: begin
          r_in_valid_1 <= 1'b0;
          r_in_valid_2 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_in_valid_1 = r_in_valid_1;
  assign bus.res_in_valid_2 = r_in_valid_2;
  assign bus.res_in_data    = r_in_data;

  // Colliding returns are a protocol error; FIFO 1 keeps the item.
  assign w_push_1 = bus.res_out_valid_1;
  assign w_push_2 = bus.res_out_valid_2 && !bus.res_out_valid_1;
  assign w_pop_1  = bus.resp_ready_1 && !w_empty_1;
  assign w_pop_2  = bus.resp_ready_2 && !w_empty_2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credit_1 <= CNT_W'(RESP_DEPTH);
      r_credit_2 <= CNT_W'(RESP_DEPTH);
    end else begin
      r_credit_1 <= credit_nxt(r_credit_1, w_acc_1, w_pop_1);
      r_credit_2 <= credit_nxt(r_credit_2, w_acc_2, w_pop_2);
    end
  end

  shared_resource_arbiter_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_fifo_1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push_1),
    .i_push_data (bus.res_out_data),
    .i_pop       (w_pop_1),
    .o_full      (w_full_1),
    .o_empty     (w_empty_1),
    .o_head      (w_head_1)
  );

  shared_resource_arbiter_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_fifo_2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push_2),
    .i_push_data (bus.res_out_data),
    .i_pop       (w_pop_2),
    .o_full      (w_full_2),
    .o_empty     (w_empty_2),
    .o_head      (w_head_2)
  );

  assign bus.resp_valid_1 = !w_empty_1;
  assign bus.resp_valid_2 = !w_empty_2;
  assign bus.resp_data_1  = w_head_1;
  assign bus.resp_data_2  = w_head_2;

  // Credits make an overflowing push impossible; collisions come only from a misbehaving resource.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.res_out_valid_1 && bus.res_out_valid_2))
        else $error("shared_resource_arbiter: res_out_valid_1 and res_out_valid_2 both high");
      assert (!(w_push_1 && w_full_1 && !w_pop_1))
        else $error("shared_resource_arbiter: push into full response FIFO 1");
      assert (!(w_push_2 && w_full_2 && !w_pop_2))
        else $error("shared_resource_arbiter: push into full response FIFO 2");
    end
  end

endmodule
